// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter for a read master and a write master sharing
//            one pipelined memory port, with outstanding-read and burst caps.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int MAX_PEND   = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    input  logic [BE_WIDTH-1:0]   rd_byteenable,
    input  logic                  rd_read,
    output logic                  rd_waitrequest,
    output logic [DATA_WIDTH-1:0] rd_readdata,
    output logic                  rd_readdataready,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [BE_WIDTH-1:0]   wr_byteenable,
    input  logic [DATA_WIDTH-1:0] wr_writedata,
    input  logic                  wr_write,
    output logic                  wr_waitrequest,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BE_WIDTH-1:0]   mem_byteenable,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_readdataready,
    input  logic                  mem_waitrequest,
    output logic [2:0]            pending,
    output logic                  idle,
    output logic                  rsp_err
);

    localparam logic [1:0] c_idle      = 2'd0;
    localparam logic [1:0] c_rd        = 2'd1;
    localparam logic [1:0] c_wr        = 2'd2;
    localparam logic [2:0] c_max_pend  = 3'(MAX_PEND);
    localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

    logic [1:0] r_state;
    logic       r_last_wr;
    logic [3:0] r_burst_cnt;
    logic [2:0] r_pending;
    logic       r_rsp_err;

    logic w_rd_eff;
    logic w_wr_eff;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_burst_last;
    logic w_burst_sat;

    // A read blocked by the outstanding limit is treated as no request at all.
    assign w_rd_eff     = rd_read && (r_pending < c_max_pend);
    assign w_wr_eff     = wr_write;
    assign w_rd_acc     = (r_state == c_rd) && w_rd_eff && !mem_waitrequest;
    assign w_wr_acc     = (r_state == c_wr) && w_wr_eff && !mem_waitrequest;
    assign w_burst_last = ({1'b0, r_burst_cnt} + 5'd1) >= {1'b0, c_max_burst};
    assign w_burst_sat  = (r_burst_cnt == c_max_burst);

    assign rd_readdata      = mem_readdata;
    assign rd_readdataready = mem_readdataready;
    assign mem_writedata    = wr_writedata;
    assign pending          = r_pending;
    assign idle             = (r_state == c_idle) && (r_pending == 3'd0);
    assign rsp_err          = r_rsp_err;

    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = rd_address;
        mem_byteenable = rd_byteenable;
        rd_waitrequest = 1'b1;
        wr_waitrequest = 1'b1;
        case (r_state)
            c_rd: begin
                mem_read       = w_rd_eff;
                rd_waitrequest = mem_waitrequest || !w_rd_eff;
            end
            c_wr: begin
                mem_write      = w_wr_eff;
                mem_address    = wr_address;
                mem_byteenable = wr_byteenable;
                wr_waitrequest = mem_waitrequest || !w_wr_eff;
            end
            default: ;
        endcase
    end

    // Burst count saturates so a lone master can stream indefinitely yet still
    // yields on its next accept once the other side starts requesting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= c_idle;
            r_last_wr   <= 1'b1;
            r_burst_cnt <= 4'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_burst_cnt <= 4'd0;
                    if (w_rd_eff && (!w_wr_eff || r_last_wr)) begin
                        r_state <= c_rd;
                    end else if (w_wr_eff) begin
                        r_state <= c_wr;
                    end
                end
                c_rd: begin
                    if (!w_rd_eff || (w_rd_acc && w_burst_last && w_wr_eff)) begin
                        r_state     <= w_wr_eff ? c_wr : c_idle;
                        r_last_wr   <= 1'b0;
                        r_burst_cnt <= 4'd0;
                    end else if (w_rd_acc && !w_burst_sat) begin
                        r_burst_cnt <= r_burst_cnt + 4'd1;
                    end
                end
                c_wr: begin
                    if (!w_wr_eff || (w_wr_acc && w_burst_last && w_rd_eff)) begin
                        r_state     <= w_rd_eff ? c_rd : c_idle;
                        r_last_wr   <= 1'b1;
                        r_burst_cnt <= 4'd0;
                    end else if (w_wr_acc && !w_burst_sat) begin
                        r_burst_cnt <= r_burst_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state     <= c_idle;
                    r_burst_cnt <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending <= 3'd0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_rd_acc && !mem_readdataready) begin
                r_pending <= r_pending + 3'd1;
            end else if (!w_rd_acc && mem_readdataready && (r_pending != 3'd0)) begin
                r_pending <= r_pending - 3'd1;
            end
            if (mem_readdataready && (r_pending == 3'd0)) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a pipelined memory model
//            and read/write scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW        = 20;
    localparam int DW        = 16;
    localparam int BW        = DW / 8;
    localparam int MAX_PEND  = 4;
    localparam int MAX_BURST = 4;
    localparam int RSP_GAP   = 3;
    localparam int TMO       = 100;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] rd_address = '0;
    logic [BW-1:0] rd_byteenable = '0;
    logic          rd_read = 1'b0;
    logic          rd_waitrequest;
    logic [DW-1:0] rd_readdata;
    logic          rd_readdataready;
    logic [AW-1:0] wr_address = '0;
    logic [BW-1:0] wr_byteenable = '0;
    logic [DW-1:0] wr_writedata = '0;
    logic          wr_write = 1'b0;
    logic          wr_waitrequest;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteenable;
    logic [DW-1:0] mem_writedata;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_readdata = '0;
    logic          mem_readdataready;
    logic          mem_waitrequest = 1'b0;
    logic [2:0]    pending;
    logic          idle;
    logic          rsp_err;

    logic rsp_rdy    = 1'b0;
    logic inject_rdy = 1'b0;
    assign mem_readdataready = rsp_rdy | inject_rdy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int max_pend = 0;

    rsp_t                  rsp_q[$];
    logic [DW-1:0]         exp_rd_q[$];
    logic [BW+AW+DW-1:0]   exp_wr_q[$];
    int                    rd_acc_q[$];
    int                    wr_acc_q[$];
    int                    rdy_cyc_q[$];
    rsp_t                  mon_r;
    logic [DW-1:0]         exp_r;
    logic [BW+AW+DW-1:0]   exp_w;

    mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BE_WIDTH  (BW),
        .MAX_PEND  (MAX_PEND),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .rd_address       (rd_address),
        .rd_byteenable    (rd_byteenable),
        .rd_read          (rd_read),
        .rd_waitrequest   (rd_waitrequest),
        .rd_readdata      (rd_readdata),
        .rd_readdataready (rd_readdataready),
        .wr_address       (wr_address),
        .wr_byteenable    (wr_byteenable),
        .wr_writedata     (wr_writedata),
        .wr_write         (wr_write),
        .wr_waitrequest   (wr_waitrequest),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_readdata     (mem_readdata),
        .mem_readdataready(mem_readdataready),
        .mem_waitrequest  (mem_waitrequest),
        .pending          (pending),
        .idle             (idle),
        .rsp_err          (rsp_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'hA5C3;
    endfunction

    // Memory model: data for a read accepted in cycle k appears in cycle k+RSP_GAP+1.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                rsp_rdy      = 1'b1;
                mem_readdata = rsp_q[0].data;
                rsp_q.delete(0);
            end else begin
                rsp_rdy      = 1'b0;
                mem_readdata = '0;
            end
        end
    end

    // Monitor and scoreboard
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                checks++;
                if ((mem_read && mem_write) !== 1'b0) begin
                    failures++;
                    $display("FAIL strobe_excl: mem_read=%0b mem_write=%0b, required not both high", mem_read, mem_write);
                end
                if (int'(pending) > max_pend) max_pend = int'(pending);
                if (mem_read && !mem_waitrequest) begin
                    mon_r.due  = cyc + RSP_GAP + 1;
                    mon_r.data = mem_fn(mem_address);
                    rsp_q.push_back(mon_r);
                end
                if (mem_write && !mem_waitrequest) begin
                    checks++;
                    if (exp_wr_q.size() == 0) begin
                        failures++;
                        $display("FAIL wr_unexpected: addr=%h data=%h, required no write", mem_address, mem_writedata);
                    end else begin
                        exp_w = exp_wr_q.pop_front();
                        if ({mem_byteenable, mem_address, mem_writedata} !== exp_w) begin
                            failures++;
                            $display("FAIL wr_data: got %h, required %h", {mem_byteenable, mem_address, mem_writedata}, exp_w);
                        end
                    end
                end
                if (rd_readdataready && !inject_rdy) begin
                    rdy_cyc_q.push_back(cyc);
                    checks++;
                    if (exp_rd_q.size() == 0) begin
                        failures++;
                        $display("FAIL rd_unexpected: data=%h, required no response", rd_readdata);
                    end else begin
                        exp_r = exp_rd_q.pop_front();
                        if (rd_readdata !== exp_r) begin
                            failures++;
                            $display("FAIL rd_data: got %h, required %h", rd_readdata, exp_r);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic rd_master(input int n, input logic [AW-1:0] base);
        for (int i = 0; i < n; i++) begin
            int t;
            rd_address    = base + AW'(i);
            rd_byteenable = BW'(i + 1);
            rd_read       = 1'b1;
            t = 0;
            @(negedge clock);
            while (rd_waitrequest && t < TMO) begin
                @(negedge clock);
                t++;
            end
            if (rd_waitrequest) begin
                checks++;
                failures++;
                $display("FAIL rd_accept_timeout: waitrequest=%0b after %0d cycles, required 0", rd_waitrequest, TMO);
                rd_read = 1'b0;
                return;
            end
            exp_rd_q.push_back(mem_fn(rd_address));
            rd_acc_q.push_back(cyc);
            sync();
        end
        rd_read = 1'b0;
    endtask

    task automatic wr_master(input int n, input logic [AW-1:0] base);
        for (int i = 0; i < n; i++) begin
            int t;
            wr_address    = base + AW'(i);
            wr_byteenable = BW'(3 - (i % 3));
            wr_writedata  = 16'h5A00 ^ DW'(i * 7);
            wr_write      = 1'b1;
            exp_wr_q.push_back({wr_byteenable, wr_address, wr_writedata});
            t = 0;
            @(negedge clock);
            while (wr_waitrequest && t < TMO) begin
                @(negedge clock);
                t++;
            end
            if (wr_waitrequest) begin
                checks++;
                failures++;
                $display("FAIL wr_accept_timeout: waitrequest=%0b after %0d cycles, required 0", wr_waitrequest, TMO);
                wr_write = 1'b0;
                return;
            end
            wr_acc_q.push_back(cyc);
            sync();
        end
        wr_write = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((rsp_q.size() != 0 || !idle || rsp_rdy) && t < TMO) begin
            @(negedge clock);
            t++;
        end
        checks++;
        if (idle !== 1'b1 || pending !== 3'd0) begin
            failures++;
            $display("FAIL drain: idle=%0b pending=%0d, required idle=1 pending=0", idle, pending);
        end
        checks++;
        if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left: rd=%0d wr=%0d entries, required 0", exp_rd_q.size(), exp_wr_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({mem_read, mem_write, rd_waitrequest, wr_waitrequest, idle, rsp_err} !== 6'b001110) begin
            failures++;
            $display("FAIL reset_outputs: got %b, required 001110", {mem_read, mem_write, rd_waitrequest, wr_waitrequest, idle, rsp_err});
        end
        checks++;
        if (pending !== 3'd0) begin
            failures++;
            $display("FAIL reset_pending: got %0d, required 0", pending);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({mem_read, mem_write, rd_waitrequest, wr_waitrequest, idle, rsp_err} !== 6'b001110) begin
            failures++;
            $display("FAIL post_reset_idle: got %b, required 001110", {mem_read, mem_write, rd_waitrequest, wr_waitrequest, idle, rsp_err});
        end
    endtask

    task automatic test_round_robin();
        int c0;
        rd_acc_q.delete();
        wr_acc_q.delete();
        sync();
        c0 = cyc;
        fork
            rd_master(8, 20'h01000);
            wr_master(8, 20'h02000);
        join
        checks++;
        if (rd_acc_q.size() != 8 || wr_acc_q.size() != 8) begin
            failures++;
            $display("FAIL rr_counts: rd=%0d wr=%0d accepts, required 8 and 8", rd_acc_q.size(), wr_acc_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (rd_acc_q[i] !== c0 + 1 + (i / 4) * 8 + (i % 4)) begin
                    failures++;
                    $display("FAIL rr_rd_slot%0d: cycle %0d, required %0d", i, rd_acc_q[i] - c0, 1 + (i / 4) * 8 + (i % 4));
                end
                checks++;
                if (wr_acc_q[i] !== c0 + 5 + (i / 4) * 8 + (i % 4)) begin
                    failures++;
                    $display("FAIL rr_wr_slot%0d: cycle %0d, required %0d", i, wr_acc_q[i] - c0, 5 + (i / 4) * 8 + (i % 4));
                end
            end
        end
        wait_drain();
    endtask

    task automatic test_pend_limit();
        int c0;
        rd_acc_q.delete();
        rdy_cyc_q.delete();
        max_pend = 0;
        sync();
        c0 = cyc;
        rd_master(5, 20'h03000);
        wait_drain();
        checks++;
        if (rd_acc_q.size() != 5) begin
            failures++;
            $display("FAIL pend_count: %0d accepts, required 5", rd_acc_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_acc_q[i] !== c0 + 1 + i) begin
                    failures++;
                    $display("FAIL pend_stream%0d: cycle %0d, required %0d", i, rd_acc_q[i] - c0, 1 + i);
                end
            end
            checks++;
            if (rdy_cyc_q.size() == 0 || rd_acc_q[4] <= rdy_cyc_q[0] || rd_acc_q[4] > rdy_cyc_q[0] + 2) begin
                failures++;
                $display("FAIL pend_fifth: accept cycle %0d, required 1..2 cycles after first response", rd_acc_q[4] - c0);
            end
        end
        checks++;
        if (max_pend !== MAX_PEND) begin
            failures++;
            $display("FAIL pend_peak: got %0d, required %0d", max_pend, MAX_PEND);
        end
    endtask

    task automatic test_wait_hold();
        int wacc;
        int racc;
        int t;
        sync();
        mem_waitrequest = 1'b1;
        wr_address      = 20'h0ABCD;
        wr_byteenable   = 2'b10;
        wr_writedata    = 16'hBEEF;
        wr_write        = 1'b1;
        exp_wr_q.push_back({wr_byteenable, wr_address, wr_writedata});
        sync();
        rd_address    = 20'h04000;
        rd_byteenable = 2'b11;
        rd_read       = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checks++;
            if ({mem_write, mem_read, wr_waitrequest, rd_waitrequest} !== 4'b1011 || mem_address !== 20'h0ABCD) begin
                failures++;
                $display("FAIL hold_cycle%0d: strobes=%b addr=%h, required 1011 addr=0abcd", k,
                         {mem_write, mem_read, wr_waitrequest, rd_waitrequest}, mem_address);
            end
            sync();
        end
        mem_waitrequest = 1'b0;
        @(negedge clock);
        wacc = cyc;
        checks++;
        if (wr_waitrequest !== 1'b0) begin
            failures++;
            $display("FAIL hold_release: wr_waitrequest=%0b, required 0", wr_waitrequest);
        end
        sync();
        wr_write = 1'b0;
        t = 0;
        @(negedge clock);
        while (rd_waitrequest && t < TMO) begin
            @(negedge clock);
            t++;
        end
        racc = cyc;
        if (!rd_waitrequest) exp_rd_q.push_back(mem_fn(rd_address));
        sync();
        rd_read = 1'b0;
        checks++;
        if (racc <= wacc || racc > wacc + 2) begin
            failures++;
            $display("FAIL hold_handover: read accepted %0d cycles after write, required 1..2", racc - wacc);
        end
        wait_drain();
    endtask

    task automatic test_same_cycle();
        int c0;
        rd_acc_q.delete();
        sync();
        c0 = cyc;
        rd_master(2, 20'h05000);
        sync();
        rd_master(1, 20'h05100);
        @(negedge clock);
        checks++;
        if (rd_acc_q.size() != 3 || rd_acc_q[2] !== c0 + 5) begin
            failures++;
            $display("FAIL same_cycle_accept: %0d accepts, last at cycle %0d, required 3 with last at 5",
                     rd_acc_q.size(), (rd_acc_q.size() > 0) ? rd_acc_q[rd_acc_q.size() - 1] - c0 : -1);
        end
        checks++;
        if (pending !== 3'd2) begin
            failures++;
            $display("FAIL same_cycle_pending: got %0d, required 2", pending);
        end
        wait_drain();
    endtask

    task automatic test_rsp_err();
        @(negedge clock);
        checks++;
        if (rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL rsp_err_clear: got %0b, required 0", rsp_err);
        end
        sync();
        inject_rdy = 1'b1;
        sync();
        inject_rdy = 1'b0;
        @(negedge clock);
        checks++;
        if (rsp_err !== 1'b1 || pending !== 3'd0) begin
            failures++;
            $display("FAIL rsp_err_set: rsp_err=%0b pending=%0d, required 1 and 0", rsp_err, pending);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (rsp_err !== 1'b1) begin
            failures++;
            $display("FAIL rsp_err_sticky: got %0b, required 1", rsp_err);
        end
    endtask

    task automatic test_reset_mid();
        sync();
        rd_master(3, 20'h06000);
        mem_waitrequest = 1'b1;
        rd_address      = 20'h06010;
        rd_read         = 1'b1;
        @(negedge clock);
        checks++;
        if (pending !== 3'd3 || mem_read !== 1'b1) begin
            failures++;
            $display("FAIL mid_setup: pending=%0d mem_read=%0b, required 3 and 1", pending, mem_read);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_read, mem_write, rd_waitrequest, wr_waitrequest, idle, rsp_err} !== 6'b001110) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %b, required 001110", {mem_read, mem_write, rd_waitrequest, wr_waitrequest, idle, rsp_err});
        end
        checks++;
        if (pending !== 3'd0) begin
            failures++;
            $display("FAIL mid_reset_pending: got %0d, required 0", pending);
        end
        rsp_q.delete();
        exp_rd_q.delete();
        rsp_rdy         = 1'b0;
        rd_read         = 1'b0;
        mem_waitrequest = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (idle !== 1'b1 || pending !== 3'd0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_after: idle=%0b pending=%0d rsp_err=%0b, required 1 0 0", idle, pending, rsp_err);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_pend_limit();
        test_wait_hold();
        test_same_cycle();
        test_rsp_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
